// File: rtl/spi_ram_responder.sv
// SPI mode-0 slave emulating a byte-addressed SPI RAM (READ 0x03 / WRITE 0x02, 24-bit address).
// All SPI pins are oversampled in the clk domain; backing store is an internal byte array.
module spi_ram_responder #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy,
  output logic cmd_err
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_RD_DATA,
    S_WR_DATA,
    S_IGNORE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [7:0]             r_shift;
  logic [7:0]             r_tx;
  logic                   r_rd;
  logic                   r_tx_load;
  logic                   r_wr_pend;
  logic [7:0]             r_mem [DEPTH];

  logic                   w_sck;
  logic                   w_cs_n;
  logic                   w_mosi;
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic [7:0]             w_rx_byte;
  logic [ADDR_BITS-1:0]   w_addr_inc;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_rx_byte  = {r_shift[6:0], w_mosi};
  assign w_addr_inc = r_addr + ADDR_BITS'(1);

  // Input synchronizers; CS resets to its idle (high) level so release is not seen as a select.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
    end else begin
      r_sck_sync[0]  <= spi_clk;
      r_cs_sync[0]   <= spi_cs_n;
      r_mosi_sync[0] <= spi_mosi;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_sck_sync[i]  <= r_sck_sync[i-1];
        r_cs_sync[i]   <= r_cs_sync[i-1];
        r_mosi_sync[i] <= r_mosi_sync[i-1];
      end
      r_sck_d <= w_sck;
    end
  end

  // Protocol FSM; a completed write byte commits even if CS rises on the same clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_addr    <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_rd      <= 1'b0;
      r_tx_load <= 1'b0;
      r_wr_pend <= 1'b0;
      spi_miso  <= 1'b0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_err   <= 1'b0;
      r_tx_load <= 1'b0;
      r_wr_pend <= 1'b0;
      if (r_wr_pend) r_addr <= w_addr_inc;
      if (w_cs_n) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
        busy      <= 1'b0;
        spi_miso  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state   <= S_CMD;
            r_bit_cnt <= '0;
            busy      <= 1'b1;
            spi_miso  <= 1'b0;
          end
          S_CMD: if (w_sck_rise) begin
            r_shift   <= w_rx_byte;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == CNT_W'(7)) begin
              r_bit_cnt <= '0;
              if (w_rx_byte == 8'h03) begin
                r_rd    <= 1'b1;
                r_state <= S_ADDR;
              end else if (w_rx_byte == 8'h02) begin
                r_rd    <= 1'b0;
                r_state <= S_ADDR;
              end else begin
                r_state <= S_IGNORE;
                cmd_err <= 1'b1;
              end
            end
          end
          S_ADDR: if (w_sck_rise) begin
            r_addr    <= {r_addr[ADDR_BITS-2:0], w_mosi};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == CNT_W'(23)) begin
              r_bit_cnt <= '0;
              r_state   <= r_rd ? S_RD_DATA : S_WR_DATA;
              r_tx_load <= r_rd;
            end
          end
          S_RD_DATA: begin
            if (r_tx_load) begin
              r_tx <= r_mem[r_addr];
            end else if (w_sck_fall) begin
              spi_miso <= r_tx[7];
              if (r_bit_cnt == CNT_W'(7)) begin
                r_bit_cnt <= '0;
                r_tx      <= r_mem[w_addr_inc];
                r_addr    <= w_addr_inc;
              end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                r_tx      <= {r_tx[6:0], 1'b0};
              end
            end
          end
          S_WR_DATA: if (w_sck_rise) begin
            r_shift   <= w_rx_byte;
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == CNT_W'(7)) begin
              r_bit_cnt <= '0;
              r_wr_pend <= 1'b1;
            end
          end
          S_IGNORE: spi_miso <= 1'b0;
          default:  r_state  <= S_IDLE;
        endcase
      end
    end
  end

  // Backing store is intentionally not reset.
  always_ff @(posedge clk) begin
    if (r_wr_pend) r_mem[r_addr] <= r_shift;
  end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed + randomized bench for spi_ram_responder; a byte-array model predicts every read.
module tb_spi_ram_responder;

  localparam int H = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic spi_clk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic busy;
  logic cmd_err;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  logic [7:0] model [256];
  logic [7:0] wbuf [$];

  spi_ram_responder #(.ADDR_BITS(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .spi_clk  (spi_clk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_err === 1'b1) err_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit: drive MOSI low phase, sample MISO just before the rising edge.
  task automatic bit_xfer(input logic mo, output logic mi);
    spi_mosi = mo;
    wait_clk(H);
    mi = spi_miso;
    spi_clk = 1'b1;
    wait_clk(H);
    spi_clk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    wait_clk(H);
    check("busy_on", busy, 1);
  endtask

  task automatic cs_end();
    wait_clk(H);
    spi_cs_n = 1'b1;
    wait_clk(H);
    check("busy_off", busy, 0);
    check("miso_idle", spi_miso, 0);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    xfer_byte(op, d);
    xfer_byte(a[23:16], d);
    xfer_byte(a[15:8], d);
    xfer_byte(a[7:0], d);
  endtask

  task automatic do_write(input logic [23:0] a);
    logic [7:0] d;
    cs_begin();
    send_hdr(8'h02, a);
    for (int i = 0; i < wbuf.size(); i++) begin
      xfer_byte(wbuf[i], d);
      model[(int'(a) + i) % 256] = wbuf[i];
    end
    cs_end();
  endtask

  task automatic do_read(input string tag, input logic [23:0] a, input int n);
    logic [7:0] rx;
    cs_begin();
    send_hdr(8'h03, a);
    for (int i = 0; i < n; i++) begin
      xfer_byte(8'($urandom), rx);
      check(tag, rx, model[(int'(a) + i) % 256]);
    end
    cs_end();
  endtask

  initial begin
    logic b;
    logic [7:0] d;
    int e0;
    int nz;
    int n;
    logic [23:0] a;

    reset_n = 1'b0; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    wait_clk(4);
    check("rst_miso", spi_miso, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_err", cmd_err, 0);
    reset_n = 1'b1;
    wait_clk(H);
    check("post_rst_busy", busy, 0);

    // Write then read
    wbuf = '{8'hA5};
    do_write(24'h000010);
    do_read("wr_rd_10", 24'h000010, 1);

    // Burst with address wrap
    wbuf = '{8'h11, 8'h22, 8'h33};
    do_write(24'h0000FE);
    do_read("wrap_burst", 24'h0000FE, 3);
    do_read("wrap_at_00", 24'h000000, 1);

    // Unsupported opcode
    cs_begin();
    d = 8'h9F;
    for (int i = 7; i >= 1; i--) bit_xfer(d[i], b);
    e0 = err_pulses;
    check("no_early_err", e0, 0);
    bit_xfer(d[0], b);
    wait_clk(4);
    check("cmd_err_width", err_pulses - e0, 1);
    nz = 0;
    for (int i = 0; i < 32; i++) begin
      bit_xfer(1'($urandom), b);
      if (b !== 1'b0) nz++;
    end
    check("ignore_miso_zero", nz, 0);
    cs_end();
    do_read("after_bad_op", 24'h000010, 1);

    // Partial write of 5 bits is discarded
    wbuf = '{8'h3C};
    do_write(24'h000020);
    cs_begin();
    send_hdr(8'h02, 24'h000020);
    for (int i = 0; i < 5; i++) bit_xfer(1'($urandom), b);
    cs_end();
    do_read("partial5_20", 24'h000020, 1);

    // 12 data bits: first byte commits, trailing nibble discarded
    wbuf = '{8'h6E, 8'h91};
    do_write(24'h000030);
    cs_begin();
    send_hdr(8'h02, 24'h000030);
    xfer_byte(8'hC3, d);
    model[8'h30] = 8'hC3;
    for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), b);
    cs_end();
    do_read("partial12_30", 24'h000030, 2);

    // Upper address bits are ignored
    wbuf = '{8'h5A};
    do_write(24'hABCD07);
    do_read("alias_07", 24'h000007, 1);

    // Randomized bursts, read back through an aliased address
    for (int k = 0; k < 6; k++) begin
      a = 24'($urandom);
      n = int'($urandom_range(1, 4));
      wbuf.delete();
      for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom));
      do_write(a);
      do_read("rand_burst", {16'($urandom), a[7:0]}, n);
    end

    check("no_spurious_err", err_pulses, 1);

    // Reset during the 3rd data bit of a read (that bit of 0xA5 is a 1)
    cs_begin();
    send_hdr(8'h03, 24'h000010);
    bit_xfer(1'b0, b);
    bit_xfer(1'b0, b);
    spi_mosi = 1'b0;
    wait_clk(5);
    check("pre_rst_miso", spi_miso, 1);
    reset_n = 1'b0;
    #1;
    check("midrd_rst_miso", spi_miso, 0);
    check("midrd_rst_busy", busy, 0);
    spi_cs_n = 1'b1;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(H);
    check("post_midrd_busy", busy, 0);
    do_read("after_rst_10", 24'h000010, 1);
    do_read("after_rst_fe", 24'h0000FE, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
